ps2_hit_encoder: RTL

- Front end that produces the 3-bit mole-hit code consumed by the game datapath's hit input.
- Receives PS/2 keyboard frames (scan code set 2) and decodes make/break codes for keys 1..5.
- Emits one hit code per physical key press: 3'd1 for key 1 through 3'd5 for key 5, and 3'd0 when idle.
- Sits between the PS/2 pins and the main datapath, in the system clock domain.

---
 rtl/ps2_hit_encoder_pkg.sv | 27 ++
 rtl/ps2_byte_rx.sv | 98 +++++++++
 rtl/ps2_hit_encoder.sv | 75 +++++++
 3 files changed

// File: rtl/ps2_hit_encoder_pkg.sv
// ps2_hit_encoder_pkg: scan codes, receiver states and hit codes for the PS/2 hit front end
package ps2_hit_encoder_pkg;
  localparam logic [7:0] KEY1_MAKE = 8'h16;
  localparam logic [7:0] KEY2_MAKE = 8'h1E;
  localparam logic [7:0] KEY3_MAKE = 8'h26;
  localparam logic [7:0] KEY4_MAKE = 8'h25;
  localparam logic [7:0] KEY5_MAKE = 8'h2E;
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam logic [2:0] HIT_NONE = 3'd0;
  localparam logic [2:0] HIT_1 = 3'd1;
  localparam logic [2:0] HIT_2 = 3'd2;
  localparam logic [2:0] HIT_3 = 3'd3;
  localparam logic [2:0] HIT_4 = 3'd4;
  localparam logic [2:0] HIT_5 = 3'd5;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
  function automatic logic [2:0] key_hit(input logic [7:0] code);
    return code == KEY1_MAKE ? HIT_1 :
           code == KEY2_MAKE ? HIT_2 :
           code == KEY3_MAKE ? HIT_3 :
           code == KEY4_MAKE ? HIT_4 :
           code == KEY5_MAKE ? HIT_5 : HIT_NONE;
  endfunction
  function automatic logic [4:0] hit_mask(input logic [2:0] hit);
    return hit == HIT_NONE ? 5'd0 : 5'd1 << (hit - 3'd1);
  endfunction
endpackage

// File: rtl/ps2_byte_rx.sv
// ps2_byte_rx: synchronises the PS/2 lines and deframes 11-bit frames into checked bytes
module ps2_byte_rx
  import ps2_hit_encoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_error_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] clk_sync_q, dat_sync_q;
  logic clk_prev_q;
  rx_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic valid_q, valid_d, err_q, err_d;
  logic fall, dat, busy;
  assign fall = clk_prev_q & ~clk_sync_q[1];
  assign dat = dat_sync_q[1];
  assign busy = state_q != IDLE;
  assign byte_o = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_error_o = err_q;
  // two-flop synchronisers plus the previous synced clock for falling-edge detection
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      clk_prev_q <= clk_sync_q[1];
    end
  // frame state, shift register, timeout counter and result pulses
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      tmo_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      par_q <= par_d;
      tmo_q <= tmo_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  // one frame bit per falling edge; a stalled frame is abandoned after the timeout
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    par_d = par_q;
    tmo_d = busy ? tmo_q + TW'(1) : '0;
    valid_d = 1'b0;
    err_d = 1'b0;
    if (fall) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          state_d = dat ? IDLE : DATA;
          cnt_d = '0;
        end
        DATA: begin
          shift_d = {dat, shift_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          state_d = cnt_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d = dat;
          state_d = STOP;
        end
        default: begin
          valid_d = dat & (^{shift_q, par_q});
          err_d = ~(dat & (^{shift_q, par_q}));
          state_d = IDLE;
        end
      endcase
    end else if (busy && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      tmo_d = '0;
      err_d = 1'b1;
    end
  end
endmodule

// File: rtl/ps2_hit_encoder.sv
// ps2_hit_encoder: turns PS/2 make/break codes for keys 1..5 into one hit code per press
module ps2_hit_encoder
  import ps2_hit_encoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [2:0] hit_code,
  output logic [4:0] key_down,
  output logic       frame_error
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [7:0] rx_byte;
  logic rx_valid;
  logic brk_q, brk_d, ext_q, ext_d;
  logic [4:0] down_q, down_d;
  logic [2:0] hit_q, hit_d, key;
  logic [HW-1:0] hold_q, hold_d;
  logic [4:0] mask;
  ps2_byte_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clock(clock),
    .reset(reset),
    .ps2_clk_i(ps2_clk),
    .ps2_dat_i(ps2_dat),
    .byte_o(rx_byte),
    .byte_valid_o(rx_valid),
    .frame_error_o(frame_error)
  );
  assign key = key_hit(rx_byte);
  assign mask = hit_mask(key);
  assign hit_code = hit_q;
  assign key_down = down_q;
  // decoder flags, held-key map and the hit output with its hold counter
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      down_q <= '0;
      hit_q <= HIT_NONE;
      hold_q <= '0;
    end else begin
      brk_q <= brk_d;
      ext_q <= ext_d;
      down_q <= down_d;
      hit_q <= hit_d;
      hold_q <= hold_d;
    end
  // prefixes arm flags, breaks release keys, first make of an idle key fires a hit
  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    down_d = down_q;
    hit_d = hold_q <= HW'(1) ? HIT_NONE : hit_q;
    hold_d = hold_q == '0 ? '0 : hold_q - HW'(1);
    if (rx_valid) begin
      if (rx_byte == BREAK_PREFIX) brk_d = 1'b1;
      else if (rx_byte == EXT_PREFIX) ext_d = 1'b1;
      else if (ext_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        brk_d = 1'b0;
        down_d = down_q & ~mask;
      end else if (|mask && ~|(down_q & mask)) begin
        down_d = down_q | mask;
        hit_d = key;
        hold_d = HW'(HOLD_CYCLES);
      end
    end
  end
endmodule
